// File: rtl/mem_port_arbiter.sv
// Shares one unified SRAM port between fetch and data requesters.
// Data has fixed priority; each access holds ext_en for WAIT_CYCLES cycles, then pulses ready.
module mem_port_arbiter #(
  parameter int ADDRESS_LEN = 32,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [ADDRESS_LEN-1:0] if_addr,
  output logic [ADDRESS_LEN-1:0] if_rdata,
  output logic                   if_ready,
  output logic                   if_stall,
  input  logic                   mem_rd_en,
  input  logic                   mem_wr_en,
  input  logic [ADDRESS_LEN-1:0] mem_addr,
  input  logic [ADDRESS_LEN-1:0] mem_wdata,
  output logic [ADDRESS_LEN-1:0] mem_rdata,
  output logic                   mem_ready,
  output logic                   mem_stall,
  output logic                   ext_en,
  output logic                   ext_we,
  output logic [ADDRESS_LEN-1:0] ext_addr,
  output logic [ADDRESS_LEN-1:0] ext_wdata,
  input  logic [ADDRESS_LEN-1:0] ext_rdata
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   owner_mem_q, owner_mem_d;
  logic                   we_q, we_d;
  logic [ADDRESS_LEN-1:0] addr_q, addr_d;
  logic [ADDRESS_LEN-1:0] wdata_q, wdata_d;
  logic [ADDRESS_LEN-1:0] if_rdata_q, if_rdata_d;
  logic [ADDRESS_LEN-1:0] mem_rdata_q, mem_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_mem_q <= owner_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_mem_d = owner_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        // Data first: the MEM-stage access belongs to the older instruction.
        if (mem_rd_en || mem_wr_en) begin
          owner_mem_d = 1'b1;
          addr_d      = mem_addr;
          wdata_d     = mem_wdata;
          we_d        = mem_wr_en;
          cnt_d       = CW'(WAIT_CYCLES - 1);
          state_d     = S_ACCESS;
        end else if (if_req) begin
          owner_mem_d = 1'b0;
          addr_d      = if_addr;
          wdata_d     = mem_wdata;
          we_d        = 1'b0;
          cnt_d       = CW'(WAIT_CYCLES - 1);
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (owner_mem_q) mem_rdata_d = ext_rdata;
            else             if_rdata_d  = ext_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ext_en    = (state_q == S_ACCESS);
  assign ext_we    = ext_en & we_q;
  assign ext_addr  = addr_q;
  assign ext_wdata = wdata_q;

  assign if_ready  = (state_q == S_RESP) & ~owner_mem_q;
  assign mem_ready = (state_q == S_RESP) &  owner_mem_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = (mem_rd_en | mem_wr_en) & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked against a
// transaction-timeline model (grant cycle g -> strobe g+1..g+W, ready g+W+1, idle from g+W+2).
module tb_mem_port_arbiter;
  localparam int AL = 32;
  localparam int W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req, mem_rd_en, mem_wr_en;
  logic [AL-1:0] if_addr, mem_addr, mem_wdata, ext_rdata;
  logic [AL-1:0] if_rdata, mem_rdata, ext_addr, ext_wdata;
  logic          if_ready, if_stall, mem_ready, mem_stall, ext_en, ext_we;

  logic          if_req1, mem_rd1, mem_wr1;
  logic [AL-1:0] if_addr1, mem_addr1, mem_wdata1, ext_rdata1;
  logic [AL-1:0] if_rdata1, mem_rdata1, ext_addr1, ext_wdata1;
  logic          if_ready1, if_stall1, mem_ready1, mem_stall1, ext_en1, ext_we1;

  mem_port_arbiter #(.ADDRESS_LEN(AL), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
    .ext_en(ext_en), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata)
  );

  mem_port_arbiter #(.ADDRESS_LEN(AL), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1), .if_stall(if_stall1),
    .mem_rd_en(mem_rd1), .mem_wr_en(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .mem_ready(mem_ready1), .mem_stall(mem_stall1),
    .ext_en(ext_en1), .ext_we(ext_we1), .ext_addr(ext_addr1), .ext_wdata(ext_wdata1), .ext_rdata(ext_rdata1)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: one outstanding transaction described by its grant cycle.
  bit            act = 1'b0;
  int            g = 0;
  bit            g_mem, g_we;
  logic [AL-1:0] m_addr, m_wdata;
  logic [AL-1:0] e_if_rd = '0, e_mem_rd = '0;

  task automatic chk(input string tag, input logic [AL-1:0] obs, input logic [AL-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    act      = 1'b0;
    e_if_rd  = '0;
    e_mem_rd = '0;
  endtask

  // Called just after a falling edge with this cycle's inputs applied; returns at the next falling edge.
  task automatic step();
    bit in_acc, rdy, idle;
    #1;
    in_acc = act && (cyc >= g + 1) && (cyc <= g + W);
    rdy    = act && (cyc == g + W + 1);
    idle   = !act || (cyc >= g + W + 2);
    chk("ext_en",    {31'b0, ext_en},    {31'b0, in_acc});
    chk("ext_we",    {31'b0, ext_we},    {31'b0, in_acc && g_we});
    chk("if_ready",  {31'b0, if_ready},  {31'b0, rdy && !g_mem});
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, rdy && g_mem});
    chk("if_stall",  {31'b0, if_stall},  {31'b0, if_req && !(rdy && !g_mem)});
    chk("mem_stall", {31'b0, mem_stall}, {31'b0, (mem_rd_en || mem_wr_en) && !(rdy && g_mem)});
    chk("if_rdata",  if_rdata,  e_if_rd);
    chk("mem_rdata", mem_rdata, e_mem_rd);
    if (in_acc) chk("ext_addr", ext_addr, m_addr);
    if (in_acc && g_we) chk("ext_wdata", ext_wdata, m_wdata);
    if (in_acc && cyc == g + W && !g_we) begin
      if (g_mem) e_mem_rd = ext_rdata;
      else       e_if_rd  = ext_rdata;
    end
    if (idle) begin
      act = 1'b0;
      if (mem_rd_en || mem_wr_en) begin
        act = 1'b1; g = cyc; g_mem = 1'b1; g_we = mem_wr_en; m_addr = mem_addr; m_wdata = mem_wdata;
      end else if (if_req) begin
        act = 1'b1; g = cyc; g_mem = 1'b0; g_we = 1'b0; m_addr = if_addr;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b1;
    if_addr = 32'h10; mem_addr = 32'h400; mem_wdata = 32'h1234; ext_rdata = 32'hFFFF_FFFF;
    if_req1 = 1'b0; mem_rd1 = 1'b0; mem_wr1 = 1'b0;
    if_addr1 = '0; mem_addr1 = '0; mem_wdata1 = '0; ext_rdata1 = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_ext_en",    {31'b0, ext_en},    32'h0);
    chk("rst_ext_we",    {31'b0, ext_we},    32'h0);
    chk("rst_ext_addr",  ext_addr,  32'h0);
    chk("rst_ext_wdata", ext_wdata, 32'h0);
    chk("rst_if_ready",  {31'b0, if_ready},  32'h0);
    chk("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
    chk("rst_if_stall",  {31'b0, if_stall},  32'h1);
    chk("rst_mem_stall", {31'b0, mem_stall}, 32'h1);
    chk("rst_if_rdata",  if_rdata,  32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    if_req = 1'b0; mem_wr_en = 1'b0;
    rst = 1'b0;
    model_reset();

    // Plain fetch
    if_req = 1'b1; if_addr = 32'h10; ext_rdata = 32'hE3A0_0001;
    repeat (5) step();
    if_req = 1'b0; step();

    // Simultaneous fetch and data read: data first
    if_req = 1'b1; if_addr = 32'h10; mem_rd_en = 1'b1; mem_addr = 32'h400; ext_rdata = 32'h0BAD_F00D;
    repeat (5) step();
    mem_rd_en = 1'b0; ext_rdata = 32'h1111_2222;
    repeat (5) step();
    if_req = 1'b0; step();

    // Data write
    mem_wr_en = 1'b1; mem_addr = 32'h404; mem_wdata = 32'hDEAD_BEEF; ext_rdata = 32'h5555_AAAA;
    repeat (5) step();
    mem_wr_en = 1'b0; step();

    // Read and write together counts as a write
    mem_rd_en = 1'b1; mem_wr_en = 1'b1; mem_addr = 32'h408; mem_wdata = 32'hCAFE_0001;
    repeat (5) step();
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; step();

    // Fetch withdrawn in cycle 2; inputs wiggle during the access
    if_req = 1'b1; if_addr = 32'h14; ext_rdata = 32'h7777_0014;
    repeat (2) step();
    if_req = 1'b0; if_addr = 32'h99; mem_addr = 32'h98;
    repeat (4) step();

    // Async reset in cycle 2 of a fetch
    if_req = 1'b1; if_addr = 32'h10; ext_rdata = 32'h4242_4242;
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_ext_en",   {31'b0, ext_en},   32'h0);
    chk("arst_if_ready", {31'b0, if_ready}, 32'h0);
    chk("arst_if_rdata", if_rdata,          32'h0);
    model_reset();
    @(posedge clk); cyc++;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) step();
    if_req = 1'b0; step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (if_req) if_req = ($urandom_range(0, 9) != 0);
      else        if_req = ($urandom_range(0, 2) == 0);
      if (mem_rd_en || mem_wr_en) begin
        if ($urandom_range(0, 9) == 0) begin mem_rd_en = 1'b0; mem_wr_en = 1'b0; end
      end else if ($urandom_range(0, 2) == 0) begin
        {mem_rd_en, mem_wr_en} = 2'($urandom_range(1, 3));
      end
      if_addr   = $urandom;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      ext_rdata = $urandom;
      step();
    end
    if_req = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;

    // Single wait-state instance: strobe in cycle 1 only, ready in cycle 2
    mem_rd1 = 1'b1; mem_addr1 = 32'h20; ext_rdata1 = 32'h0000_55AA;
    #1;
    chk("w1_c0_ext_en", {31'b0, ext_en1},    32'h0);
    chk("w1_c0_stall",  {31'b0, mem_stall1}, 32'h1);
    @(negedge clk); #1;
    chk("w1_c1_ext_en", {31'b0, ext_en1}, 32'h1);
    chk("w1_c1_addr",   ext_addr1,        32'h20);
    chk("w1_c1_ready",  {31'b0, mem_ready1}, 32'h0);
    @(negedge clk); #1;
    chk("w1_c2_ext_en", {31'b0, ext_en1},    32'h0);
    chk("w1_c2_ready",  {31'b0, mem_ready1}, 32'h1);
    chk("w1_c2_rdata",  mem_rdata1,          32'h0000_55AA);
    chk("w1_c2_stall",  {31'b0, mem_stall1}, 32'h0);
    mem_rd1 = 1'b0; ext_rdata1 = 32'h0;
    @(negedge clk); #1;
    chk("w1_c3_ready",  {31'b0, mem_ready1}, 32'h0);
    chk("w1_c3_rdata",  mem_rdata1,          32'h0000_55AA);
    chk("w1_if_side",   {30'b0, if_ready1, if_stall1}, 32'h0);
    chk("w1_if_rdata",  if_rdata1,  32'h0);
    chk("w1_we",        {31'b0, ext_we1}, 32'h0);
    chk("w1_wdata",     ext_wdata1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
